// File: rtl/rfPhoenixPkg.sv
// rfPhoenix shared types.
// Vector values, instructions and vector ALU scheduler state.
package rfPhoenixPkg;

  localparam int NLANES = 16;

  typedef logic [31:0] value_t;
  typedef value_t [NLANES-1:0] vector_value_t;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_ADDI,
    OP_MADD,
    OP_SLL
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
  } instruction_t;

  typedef logic [NLANES-1:0] lane_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } vec_sched_state_t;

  // True when any lane of group g (n lanes per group) is enabled.
  function automatic logic group_hit(
    lane_mask_t  m,
    int unsigned g,
    int unsigned n
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NLANES; i++)
      if (i / n == g) hit = hit | m[i];
    return hit;
  endfunction

endpackage

// File: rtl/rf_phoenix_lane_alu_pipe.sv
// One physical lane ALU.
// Result appears LAT cycles after the operands are presented.
module rf_phoenix_lane_alu_pipe
  import rfPhoenixPkg::*;
#(
  parameter int LAT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  instruction_t ir,
  input  value_t       a,
  input  value_t       b,
  input  value_t       c,
  input  value_t       imm,
  output value_t       y
);

  value_t f;
  value_t stage [LAT];

  // Lane operation evaluated at the pipe entry
  always_comb begin
    f = '0;
    unique case (ir.op)
      OP_ADD:  f = a + b;
      OP_SUB:  f = a - b;
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_ADDI: f = a + imm;
      OP_MADD: f = a * b + c;
      OP_SLL:  f = a << b[4:0];
      default: f = '0;
    endcase
  end

  // Fixed-latency delay of the lane result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= f;
      for (int i = 1; i < LAT; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign y = stage[LAT-1];

endmodule

// File: rtl/rf_phoenix_vec_alu_sched.sv
// Vector ALU scheduler: folds an NLANES-wide op onto NPHYS
// pipelined lane ALUs, skipping idle lane groups.
module rf_phoenix_vec_alu_sched
  import rfPhoenixPkg::*;
#(
  parameter int NLANES = 16,
  parameter int NPHYS  = 4,
  parameter int LAT    = 8,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  instruction_t    req_ir,
  input  vector_value_t   req_a,
  input  vector_value_t   req_b,
  input  vector_value_t   req_c,
  input  value_t          req_imm,
  input  lane_mask_t      req_mask,
  input  logic [TAGW-1:0] req_tag,
  output logic            res_valid,
  input  logic            res_ready,
  output vector_value_t   res,
  output logic [TAGW-1:0] res_tag,
  output logic            busy
);

  localparam int NG = NLANES / NPHYS;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef logic [GW-1:0]    grp_t;
  typedef logic [NPHYS-1:0] gmask_t;

  function automatic logic [LW-1:0] lane_of(grp_t g, int p);
    return LW'(int'(g) * NPHYS + p);
  endfunction

  vec_sched_state_t state;

  instruction_t  ir_q;
  vector_value_t a_q;
  vector_value_t b_q;
  vector_value_t c_q;
  value_t        imm_q;
  lane_mask_t    mask_q;

  logic [NG-1:0] gpend;
  logic [NG-1:0] gnext;
  logic [NG-1:0] req_grp;
  logic [CW-1:0] inflight;
  logic [CW-1:0] cnt_n;

  grp_t   cur_g;
  gmask_t issue_m;
  logic   issue;
  logic   wb;
  logic   last;

  logic   trk_v [LAT];
  grp_t   trk_g [LAT];
  gmask_t trk_m [LAT];

  value_t alu_y [NPHYS];

  // Groups of an incoming request that hold at least one live lane
  always_comb begin
    req_grp = '0;
    for (int g = 0; g < NG; g++)
      req_grp[g] = group_hit(req_mask, g, NPHYS);
  end

  // Pick lowest pending group; derive issue, writeback and count
  always_comb begin
    cur_g = '0;
    for (int g = NG - 1; g >= 0; g--)
      if (gpend[g]) cur_g = grp_t'(g);
    gnext        = gpend;
    gnext[cur_g] = 1'b0;
    last         = (gnext == '0);
    issue        = (state == ISSUE);
    issue_m      = mask_q[int'(cur_g) * NPHYS +: NPHYS];
    wb           = trk_v[LAT-1];
    cnt_n        = inflight + CW'(issue) - CW'(wb);
  end

  for (genvar p = 0; p < NPHYS; p++) begin : g_lane
    logic [LW-1:0] li;
    assign li = lane_of(cur_g, p);
    rf_phoenix_lane_alu_pipe #(
      .LAT(LAT)
    ) u_alu (
      .clk(clk),
      .rst(rst),
      .ir (ir_q),
      .a  (a_q[li]),
      .b  (b_q[li]),
      .c  (c_q[li]),
      .imm(imm_q),
      .y  (alu_y[p])
    );
  end

  // Tracking entries travel in lockstep with the lane ALU pipes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        trk_v[i] <= 1'b0;
        trk_g[i] <= '0;
        trk_m[i] <= '0;
      end
    end else begin
      trk_v[0] <= issue;
      trk_g[0] <= cur_g;
      trk_m[0] <= issue_m;
      for (int i = 1; i < LAT; i++) begin
        trk_v[i] <= trk_v[i-1];
        trk_g[i] <= trk_g[i-1];
        trk_m[i] <= trk_m[i-1];
      end
    end
  end

  // Scheduler FSM, operand capture and result buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res       <= '0;
      res_tag   <= '0;
      inflight  <= '0;
      gpend     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      imm_q     <= '0;
      mask_q    <= '0;
    end else begin
      inflight <= cnt_n;
      if (wb)
        for (int p = 0; p < NPHYS; p++)
          if (trk_m[LAT-1][p])
            res[lane_of(trk_g[LAT-1], p)] <= alu_y[p];
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            ir_q      <= req_ir;
            a_q       <= req_a;
            b_q       <= req_b;
            c_q       <= req_c;
            imm_q     <= req_imm;
            mask_q    <= req_mask;
            res       <= req_c;
            res_tag   <= req_tag;
            gpend     <= req_grp;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (|req_mask) begin
              state <= ISSUE;
            end else begin
              state     <= HOLD;
              res_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          gpend <= gnext;
          if (last) begin
            if (cnt_n == '0) begin
              state     <= HOLD;
              res_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (wb && cnt_n == '0) begin
            state     <= HOLD;
            res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_phoenix_vec_alu_sched.sv
// Bench for the vector ALU scheduler.
// Directed corner cases plus random ops against a timing/value model.
module tb_rf_phoenix_vec_alu_sched;
  import rfPhoenixPkg::*;

  localparam int NP = 4;
  localparam int LT = 8;
  localparam int TW = 4;
  localparam int NG = NLANES / NP;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  instruction_t  req_ir = '0;
  vector_value_t req_a = '0;
  vector_value_t req_b = '0;
  vector_value_t req_c = '0;
  value_t        req_imm = '0;
  lane_mask_t    req_mask = '0;
  logic [TW-1:0] req_tag = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  vector_value_t res;
  logic [TW-1:0] res_tag;
  logic          busy;

  int errors = 0;
  int checks = 0;

  rf_phoenix_vec_alu_sched #(
    .NLANES(NLANES),
    .NPHYS (NP),
    .LAT   (LT),
    .TAGW  (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ir   (req_ir),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_c    (req_c),
    .req_imm  (req_imm),
    .req_mask (req_mask),
    .req_tag  (req_tag),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res      (res),
    .res_tag  (res_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] got,
                       input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic value_t ref_alu(alu_op_t op, value_t a, value_t b,
                                     value_t c, value_t imm);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADDI: return a + imm;
      OP_MADD: return a * b + c;
      OP_SLL:  return a << b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic vector_value_t expect_vec(instruction_t ir,
      vector_value_t a, vector_value_t b, vector_value_t c,
      value_t imm, lane_mask_t m);
    vector_value_t e;
    for (int i = 0; i < NLANES; i++)
      e[i] = m[i] ? ref_alu(ir.op, a[i], b[i], c[i], imm) : c[i];
    return e;
  endfunction

  function automatic int active_groups(lane_mask_t m);
    int k;
    k = 0;
    for (int g = 0; g < NG; g++)
      if (m[g*NP +: NP] != '0) k++;
    return k;
  endfunction

  // Abstract model: busy/valid flags and a countdown to result
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  int            m_timer = 0;
  vector_value_t m_res = '0;
  logic [TW-1:0] m_tag = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_timer = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1'b1;
        m_res   = expect_vec(req_ir, req_a, req_b, req_c, req_imm, req_mask);
        m_tag   = req_tag;
        m_timer = (active_groups(req_mask) == 0) ? 0
                : active_groups(req_mask) + LT;
        m_valid = (m_timer == 0);
      end
    end else if (!m_valid) begin
      m_timer--;
      if (m_timer == 0) m_valid = 1'b1;
    end else if (res_ready) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("req_ready", 512'(req_ready), 512'(!m_busy));
    check("busy", 512'(busy), 512'(m_busy));
    check("res_valid", 512'(res_valid), 512'(m_valid));
    if (m_valid) begin
      check("res", 512'(res), 512'(m_res));
      check("res_tag", 512'(res_tag), 512'(m_tag));
    end
  end

  task automatic run_op(input instruction_t ir, input vector_value_t a,
      input vector_value_t b, input vector_value_t c, input value_t imm,
      input lane_mask_t m, input logic [TW-1:0] t, input int hold,
      output vector_value_t got, output logic [TW-1:0] gtag,
      output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_wait", 512'(req_ready), 512'(1));
    req_ir    = ir;
    req_a     = a;
    req_b     = b;
    req_c     = c;
    req_imm   = imm;
    req_mask  = m;
    req_tag   = t;
    res_ready = (hold == 0);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got  = res;
    gtag = res_tag;
    repeat (hold) @(posedge clk);
    if (hold > 0) begin
      #1;
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(output vector_value_t v);
    for (int i = 0; i < NLANES; i++) v[i] = $urandom;
  endtask

  initial begin
    instruction_t  ir;
    vector_value_t a, b, c, got, e;
    value_t        imm;
    lane_mask_t    m;
    logic [TW-1:0] gt;
    int            lat;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_res", 512'(res), 512'(0));
    check("rst_tag", 512'(res_tag), 512'(0));
    check("rst_ready", 512'(req_ready), 512'(1));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_valid", 512'(res_valid), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    ir.op = OP_ADD;
    imm   = '0;
    for (int i = 0; i < NLANES; i++) begin
      a[i] = value_t'(i);
      b[i] = 32'd100;
      c[i] = '0;
    end
    run_op(ir, a, b, c, imm, 16'hFFFF, 4'd3, 0, got, gt, lat);
    check("full_lane0", 512'(got[0]), 512'(100));
    check("full_lane15", 512'(got[15]), 512'(115));
    check("full_tag", 512'(gt), 512'(3));
    check("full_lat", 512'(lat), 512'(13));

    for (int i = 0; i < NLANES; i++) c[i] = 32'hDEAD;
    run_op(ir, a, b, c, imm, 16'h00F0, 4'd5, 0, got, gt, lat);
    check("m00f0_lane5", 512'(got[5]), 512'(105));
    check("m00f0_lane3", 512'(got[3]), 512'(32'hDEAD));
    check("m00f0_lane8", 512'(got[8]), 512'(32'hDEAD));
    check("m00f0_lat", 512'(lat), 512'(10));

    rand_vec(a);
    rand_vec(b);
    rand_vec(c);
    run_op(ir, a, b, c, imm, 16'h0000, 4'd7, 0, got, gt, lat);
    check("m0_res", 512'(got), 512'(c));
    check("m0_lat", 512'(lat), 512'(1));

    ir.op = OP_MADD;
    rand_vec(a);
    run_op(ir, a, b, c, imm, 16'hA5C3, 4'd9, 20, got, gt, lat);
    check("hold_res", 512'(got), 512'(expect_vec(ir, a, b, c, imm, 16'hA5C3)));
    check("hold_ready", 512'(req_ready), 512'(1));
    ir.op = OP_SUB;
    run_op(ir, a, b, c, imm, 16'h3C3C, 4'd1, 0, got, gt, lat);
    check("after_hold", 512'(got), 512'(expect_vec(ir, a, b, c, imm, 16'h3C3C)));

    ir.op     = OP_XOR;
    req_ir    = ir;
    req_a     = a;
    req_b     = b;
    req_c     = c;
    req_mask  = 16'hFFFF;
    req_tag   = 4'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 512'(req_ready), 512'(1));
    check("mid_rst_valid", 512'(res_valid), 512'(0));
    check("mid_rst_busy", 512'(busy), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    ir.op = OP_ADD;
    rand_vec(a);
    rand_vec(b);
    run_op(ir, a, b, c, imm, 16'hFFFF, 4'd4, 0, got, gt, lat);
    check("post_rst_res", 512'(got), 512'(expect_vec(ir, a, b, c, imm, 16'hFFFF)));
    check("post_rst_lat", 512'(lat), 512'(13));

    run_op(ir, a, b, c, imm, 16'h8001, 4'd6, 0, got, gt, lat);
    check("m8001_lat", 512'(lat), 512'(11));
    check("m8001_lane0", 512'(got[0]), 512'(a[0] + b[0]));
    check("m8001_lane15", 512'(got[15]), 512'(a[15] + b[15]));
    check("m8001_lane7", 512'(got[7]), 512'(c[7]));

    for (int n = 0; n < 40; n++) begin
      ir.op = alu_op_t'($urandom_range(0, 7));
      rand_vec(a);
      rand_vec(b);
      rand_vec(c);
      imm = $urandom;
      case ($urandom_range(0, 3))
        0: m = lane_mask_t'($urandom);
        1: m = '0;
        2: m = 16'hFFFF;
        default: m = lane_mask_t'(16'hF << (4 * $urandom_range(0, 3)));
      endcase
      e = expect_vec(ir, a, b, c, imm, m);
      run_op(ir, a, b, c, imm, m, TW'($urandom), $urandom_range(0, 3),
             got, gt, lat);
      check("rand_res", 512'(got), 512'(e));
      check("rand_lat", 512'(lat),
            512'(active_groups(m) == 0 ? 1 : active_groups(m) + LT + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
